pll_reset_cen: RTL and testbench

PLL_RESET_CEN -- requirements
Module: pll_reset_cen

---
 rtl/pll_reset_cen_pkg.sv | 11 +
 rtl/locked_sync.sv | 14 +
 rtl/pll_reset_cen.sv | 102 ++++++++++
 tb/tb_pll_reset_cen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_cen_pkg.sv
// pll_reset_cen_pkg: state encoding and default constants for the PLL reset / clock-enable block
package pll_reset_cen_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD_RST, RUN} state_e;
  localparam int CEN_NUM_DEF    = 3;
  localparam int CEN_DEN_DEF    = 16;
  localparam int LOCK_HOLD_DEF  = 1024;
  localparam int RST_CYCLES_DEF = 256;
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/locked_sync.sv
// locked_sync: two-flop synchronizer bringing the PLL lock flag into the clk domain
module locked_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  // Shift the asynchronous flag through two flops; reset clears to "not locked"
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/pll_reset_cen.sv
// pll_reset_cen: lock-qualified game reset sequencer with fractional 12/6/3 MHz clock enables
module pll_reset_cen
  import pll_reset_cen_pkg::*;
#(
  parameter int CEN_NUM    = CEN_NUM_DEF,
  parameter int CEN_DEN    = CEN_DEN_DEF,
  parameter int LOCK_HOLD  = LOCK_HOLD_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked,
  output logic game_rst,
  output logic ready,
  output logic cen12,
  output logic cen6,
  output logic cen3
);
  localparam int CMAX = max2(LOCK_HOLD, RST_CYCLES);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int AW   = $clog2(CEN_DEN) + 1;
  localparam logic [CW-1:0] LH_LAST = CW'(LOCK_HOLD - 1);
  localparam logic [CW-1:0] RC_LAST = CW'(RST_CYCLES - 1);
  localparam logic [AW-1:0] NUM     = AW'(CEN_NUM);
  localparam logic [AW-1:0] DEN     = AW'(CEN_DEN);

  if (2 * CEN_NUM > CEN_DEN || CEN_NUM == 0 || LOCK_HOLD < 1 || RST_CYCLES < 1) begin : g_param_err
    $error("pll_reset_cen: illegal parameters (need 0 < 2*CEN_NUM <= CEN_DEN, LOCK_HOLD >= 1, RST_CYCLES >= 1)");
  end

  logic          lk_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [1:0]    pc_q, pc_d;
  logic          acc_en, wrap;
  logic          cen12_q, cen6_q, cen3_q;

  locked_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (locked),
    .q_o   (lk_s)
  );

  // Sequencer: qualify lock for LOCK_HOLD cycles, then hold reset RST_CYCLES; losing lock always restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      WAIT_LOCK: state_d = QUALIFY;
      QUALIFY:   if (cnt_q == LH_LAST) state_d = HOLD_RST; else cnt_d = cnt_q + 1'b1;
      HOLD_RST:  if (cnt_q == RC_LAST) state_d = RUN;      else cnt_d = cnt_q + 1'b1;
      default:   ;
    endcase
    if (!lk_s) begin
      state_d = WAIT_LOCK;
      cnt_d   = '0;
    end
  end

  // State and shared phase counter registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  // Fractional accumulator runs from the first cycle of HOLD_RST so the core sees enables during reset
  always_comb begin
    acc_en = (state_d == HOLD_RST) || (state_d == RUN);
    sum    = acc_q + NUM;
    wrap   = acc_en && (sum >= DEN);
    acc_d  = !acc_en ? '0 : wrap ? sum - DEN : sum;
    pc_d   = !acc_en ? '0 : wrap ? pc_q + 2'd1 : pc_q;
  end

  // Accumulator, pulse counter and registered enables; cen6/cen3 derive from the pulse index
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc_q   <= '0;
      pc_q    <= '0;
      cen12_q <= 1'b0;
      cen6_q  <= 1'b0;
      cen3_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      cen12_q <= wrap;
      cen6_q  <= wrap & pc_q[0];
      cen3_q  <= wrap & (pc_q == 2'd3);
    end

  assign ready    = (state_q == RUN);
  assign game_rst = ~ready;
  assign cen12    = cen12_q;
  assign cen6     = cen6_q;
  assign cen3     = cen3_q;
endmodule

// File: tb/tb_pll_reset_cen.sv
// tb_pll_reset_cen: scenario and randomized checks of pll_reset_cen against an arithmetic lock-streak model
module tb_pll_reset_cen;
  import pll_reset_cen_pkg::*;
  localparam int N  = 3;
  localparam int D  = 16;
  localparam int LH = 1024;
  localparam int RC = 256;
  localparam int SEQ = 2 + LH + RC + 1;

  logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0;
  logic game_rst, ready, cen12, cen6, cen3;
  logic [4:0] act_o, exp_o;
  int checks = 0, passes = 0;
  int s = 0;
  bit m1 = 0, m2 = 0;

  pll_reset_cen #(.CEN_NUM(N), .CEN_DEN(D), .LOCK_HOLD(LH), .RST_CYCLES(RC)) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked),
    .game_rst(game_rst), .ready(ready), .cen12(cen12), .cen6(cen6), .cen3(cen3)
  );

  always #5 clk = ~clk;
  assign act_o = {game_rst, ready, cen12, cen6, cen3};

  // s = number of consecutive edges at which the synchronized lock was high
  function automatic logic [4:0] model_out(input int st);
    int h, k, kp;
    bit r, c;
    r  = st > LH + RC;
    h  = (st > LH) ? st - LH : 0;
    k  = h * N / D;
    kp = (h > 0) ? (h - 1) * N / D : 0;
    c  = (h > 0) && (k > kp);
    return {!r, r, c, c && (k % 2 == 0), c && (k % 4 == 0)};
  endfunction

  task automatic model_reset();
    s = 0; m1 = 0; m2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      s  = m2 ? s + 1 : 0;
      m2 = m1;
      m1 = locked;
    end
    #1;
    exp_o = model_out(s);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (act_o !== 5'b10000) $display("FAIL reset_outputs got %b expected %b", act_o, 5'b10000);
      else passes++;
    end
    checks++;
    if (dut.state_q !== WAIT_LOCK) $display("FAIL reset_state got %0d expected %0d", dut.state_q, WAIT_LOCK);
    else passes++;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_lockup();
    int rdy_at = -1, c12_at = -1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL idle_unlocked got %b expected %b", act_o, exp_o);
      else passes++;
    end
    locked = 1'b1;
    for (int n = 1; n <= SEQ + 50 && rdy_at < 0; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL lockup n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
      if (n == 2 || n == 3) begin
        checks++;
        if ((dut.state_q == QUALIFY) !== (n == 3))
          $display("FAIL qualify_entry n=%0d got state %0d expected qualify=%0d", n, dut.state_q, n == 3);
        else passes++;
      end
      if (cen12 && c12_at < 0) c12_at = n;
      if (ready && rdy_at < 0) rdy_at = n;
    end
    checks++;
    if (rdy_at != SEQ) $display("FAIL lockup_ready_cycle got %0d expected %0d", rdy_at, SEQ);
    else passes++;
    checks++;
    if (c12_at != 3 + LH + 5) $display("FAIL first_cen12_cycle got %0d expected %0d", c12_at, 3 + LH + 5);
    else passes++;
  endtask

  task automatic test_cadence();
    int c12 = 0, c6 = 0, c3 = 0, adj = 0, orphan = 0;
    bit prev = 0;
    for (int n = 0; n < 1600; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL cadence n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
      c12 += int'(cen12);
      c6  += int'(cen6);
      c3  += int'(cen3);
      if (prev && cen12) adj++;
      if ((cen6 || cen3) && !cen12) orphan++;
      prev = cen12;
    end
    checks++;
    if (c12 != 300) $display("FAIL cen12_count got %0d expected 300", c12); else passes++;
    checks++;
    if (c6 != 150) $display("FAIL cen6_count got %0d expected 150", c6); else passes++;
    checks++;
    if (c3 != 75) $display("FAIL cen3_count got %0d expected 75", c3); else passes++;
    checks++;
    if (adj != 0) $display("FAIL cen12_adjacent got %0d expected 0", adj); else passes++;
    checks++;
    if (orphan != 0) $display("FAIL cen_subrate_alone got %0d expected 0", orphan); else passes++;
  endtask

  task automatic test_lock_loss();
    locked = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL lock_loss n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
    end
    checks++;
    if ({game_rst, ready} !== 2'b10) $display("FAIL lock_loss_reset got %b expected 10", {game_rst, ready});
    else passes++;
    checks++;
    if (dut.acc_q !== '0 || dut.pc_q !== '0)
      $display("FAIL lock_loss_clear got acc=%0d pc=%0d expected 0 0", dut.acc_q, dut.pc_q);
    else passes++;
    for (int n = 0; n < 40; n++) begin
      tick();
      checks++;
      if (act_o !== 5'b10000) $display("FAIL lock_loss_quiet n=%0d got %b expected 10000", n, act_o);
      else passes++;
    end
  endtask

  task automatic test_glitch_qualify();
    int rdy_at = -1, qcnt = 0, grst_low = 0;
    bit saw_wait = 0;
    locked = 1'b1;
    for (int n = 0; n < 600 && s != 501; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL glitch_pre n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
    end
    locked = 1'b0;
    tick();
    checks++;
    if (act_o !== exp_o) $display("FAIL glitch_low got %b expected %b", act_o, exp_o);
    else passes++;
    locked = 1'b1;
    for (int n = 1; n <= SEQ + 50 && rdy_at < 0; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL glitch_post n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
      if (dut.state_q == WAIT_LOCK) saw_wait = 1;
      if (saw_wait && dut.state_q == QUALIFY) qcnt++;
      if (ready && rdy_at < 0) rdy_at = n;
      else if (!game_rst) grst_low++;
    end
    checks++;
    if (!saw_wait) $display("FAIL glitch_wait_lock got 0 expected 1"); else passes++;
    checks++;
    if (qcnt != LH) $display("FAIL glitch_requalify got %0d expected %0d", qcnt, LH); else passes++;
    checks++;
    if (grst_low != 0) $display("FAIL glitch_game_rst_drop got %0d expected 0", grst_low); else passes++;
    checks++;
    if (rdy_at != SEQ) $display("FAIL glitch_ready_cycle got %0d expected %0d", rdy_at, SEQ); else passes++;
  endtask

  task automatic test_async_reset();
    int rdy_at = -1;
    int k = $urandom_range(20, 60);
    for (int n = 0; n < k; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL async_pre n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (act_o !== 5'b10000) $display("FAIL async_outputs got %b expected 10000", act_o); else passes++;
    checks++;
    if (dut.state_q !== WAIT_LOCK) $display("FAIL async_state got %0d expected %0d", dut.state_q, WAIT_LOCK);
    else passes++;
    rst_n = 1'b1;
    model_reset();
    for (int n = 1; n <= SEQ + 50 && rdy_at < 0; n++) begin
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL async_restart n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
      if (ready) rdy_at = n;
    end
    checks++;
    if (rdy_at != SEQ) $display("FAIL async_ready_cycle got %0d expected %0d", rdy_at, SEQ); else passes++;
  endtask

  task automatic test_random();
    int low_left = 0;
    for (int n = 0; n < 6000; n++) begin
      if ($urandom_range(0, 1999) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (act_o !== 5'b10000) $display("FAIL random_async n=%0d got %b expected 10000", n, act_o);
        else passes++;
        rst_n = 1'b1;
        model_reset();
      end
      if (low_left > 0) low_left--;
      else if ($urandom_range(0, 699) == 0) low_left = $urandom_range(1, 4);
      locked = (low_left == 0);
      tick();
      checks++;
      if (act_o !== exp_o) $display("FAIL random n=%0d got %b expected %b", n, act_o, exp_o);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_lockup();
    test_cadence();
    test_lock_loss();
    test_glitch_qualify();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
